memory_reader: RTL and testbench
================================

MEMORY_READER -- requirements
Module: memory_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of word read from memory_driver.
REQ-002 SHALL have parameter BYTE_W, default 8, width of each emitted byte; DATA_W SHALL be 4*BYTE_W.
REQ-003 SHALL have parameter CNT_W, default 16, width of word_count.
REQ-004 SHALL have one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  synchronous active-high reset.
REQ-006 SHALL have empty  input  1  memory_driver has no stored word.
REQ-007 SHALL have rd_en  output  1  single-cycle read request to memory_driver.
REQ-008 SHALL have concatenated_out  input  DATA_W  word from memory_driver, valid the cycle after rd_en.
REQ-009 SHALL have out_data  output  BYTE_W  current emitted byte.
REQ-010 SHALL have out_valid  output  1  out_data holds a valid byte.
REQ-011 SHALL have out_ready  input  1  downstream accepts byte when high with out_valid.
REQ-012 SHALL have busy  output  1  high in any state except IDLE.
REQ-013 SHALL have word_count  output  CNT_W  number of words fully emitted.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, CAPT, SEND.
REQ-015 IDLE: SHALL go to REQ on the cycle empty=0; otherwise stay.
REQ-016 REQ: SHALL drive rd_en=1 for exactly that cycle, then go to CAPT; rd_en SHALL be 0 in every other state.
REQ-017 CAPT: SHALL register concatenated_out into a DATA_W shift register, set byte index to 0, go to SEND.
REQ-018 SEND: out_valid=1; out_data SHALL be the most-significant byte of the shift register (bits DATA_W-1 downto DATA_W-BYTE_W first).
REQ-019 Byte transfer SHALL occur only on a cycle with out_valid=1 and out_ready=1; on transfer the register SHALL shift left by BYTE_W and index SHALL increment.
REQ-020 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 On transfer of byte index 3: word_count SHALL increment (wrapping modulo 2^CNT_W); next state SHALL be REQ if empty=0 that cycle, else IDLE.
REQ-022 Minimum latency rd_en to first out_valid SHALL be 2 cycles; back-to-back words with out_ready=1 SHALL sustain 4 bytes per 6 cycles.
REQ-023 A change of empty during CAPT or SEND SHALL have no effect until the index-3 transfer.
REQ-024 rd_en SHALL never be asserted while empty=1 in the same cycle.

Reset
REQ-025 With rst=1 at a rising clk edge: state IDLE, rd_en=0, out_valid=0, out_data=0, busy=0, word_count=0, index=0, shift register=0.
REQ-026 rst mid-word SHALL discard remaining bytes without incrementing word_count; reset SHALL take priority over all other events.

Structure
REQ-027 DATA_W, BYTE_W, CNT_W defaults and the FSM state encoding SHALL reside in shared package memory_pkg.
REQ-028 Shift register and byte index SHALL form one sub-module, byte_serializer; FSM and word_count remain in memory_reader.

Verification
REQ-029 Reset: rst=1 two cycles -> all outputs 0, state IDLE, no rd_en.
REQ-030 Single word: empty=0 one cycle, word 0x01020304, out_ready=1 -> one rd_en pulse, bytes 0x01,0x02,0x03,0x04 on consecutive cycles, word_count=1, return to IDLE.
REQ-031 Backpressure: word 0xA1B2C3D4, out_ready low on cycles 2-4 of SEND -> out_data held 0xB2 stable, sequence A1,B2,C3,D4 intact, no extra rd_en.
REQ-032 Back-to-back: empty=0 for words 0x11223344 and 0x55667788 -> second rd_en in the cycle after 0x44 transfer, 8 bytes in order, word_count=2.
REQ-033 Reset mid-word: rst after 2 of 4 bytes of 0xDEADBEEF -> out_valid=0 next cycle, word_count unchanged, no further bytes.
REQ-034 Wrap: preload word_count to 0xFFFF (CNT_W=16), emit one word -> word_count=0x0000.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared defaults and FSM state encoding for the memory reader and its byte serializer.
package memory_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int BYTE_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_CAPT = 2'd2,
      ST_SEND = 2'd3
   } state_t;

   function automatic logic is_last_byte(input logic [1:0] idx);
      return idx == 2'd3;
   endfunction

endpackage

// File: rtl/byte_serializer.sv
// Holds one captured word and presents it MSB-byte first, shifting left on each accepted byte.
module byte_serializer
   import memory_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int BYTE_W = BYTE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift,
   output logic [BYTE_W-1:0] msb_byte,
   output logic [1:0]        index
);

   logic [DATA_W-1:0] sreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg  <= '0;
         index <= '0;
      end else if (load) begin
         sreg  <= load_data;
         index <= '0;
      end else if (shift) begin
         sreg  <= {sreg[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
         index <= index + 2'd1;
      end
   end

   assign msb_byte = sreg[DATA_W-1 -: BYTE_W];

endmodule

// File: rtl/memory_reader.sv
// Reads one word at a time from a memory driver and streams it out as four bytes, MSB first.
module memory_reader
   import memory_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int BYTE_W = BYTE_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              empty,
   output logic              rd_en,
   input  logic [DATA_W-1:0] concatenated_out,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count,
   output logic [1:0]        state
);

   // Byte handshake: a byte moves only on a cycle where out_valid and out_ready
   // are both high; while out_valid is high and out_ready low, out_data holds.
   state_t     state_q, state_d;
   logic       load;
   logic       shift;
   logic [1:0] index;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      rd_en     = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      case (state_q)
         ST_IDLE: if (!empty) state_d = ST_REQ;
         // A driver that empties before the request is honoured gets no read.
         ST_REQ: begin
            if (empty) begin
               state_d = ST_IDLE;
            end else begin
               rd_en   = 1'b1;
               state_d = ST_CAPT;
            end
         end
         ST_CAPT: begin
            load    = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            out_valid = 1'b1;
            if (out_ready && is_last_byte(index)) state_d = empty ? ST_IDLE : ST_REQ;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign shift = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst)                               word_count <= '0;
      else if (shift && is_last_byte(index)) word_count <= word_count + 1'b1;
   end

   byte_serializer #(
      .DATA_W (DATA_W),
      .BYTE_W (BYTE_W)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (concatenated_out),
      .shift     (shift),
      .msb_byte  (out_data),
      .index     (index)
   );

   assign busy  = (state_q != ST_IDLE);
   assign state = state_q;

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader: memory-driver model, byte scoreboard and literal spot checks.
module tb_memory_reader;
   import memory_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        empty = 1'b1;
   logic        rd_en;
   logic [31:0] concatenated_out = '0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic [15:0] word_count;
   logic [1:0]  dbg_state;

   logic        w_rst = 1'b1;
   logic        w_empty = 1'b1;
   logic        w_rd_en;
   logic [31:0] w_concatenated_out = 32'h0A0B0C0D;
   logic [7:0]  w_out_data;
   logic        w_out_valid;
   logic        w_busy;
   logic [3:0]  w_word_count;
   logic [1:0]  w_state;
   int          w_pending = 0;

   memory_reader dut (
      .clk(clk), .rst(rst), .empty(empty), .rd_en(rd_en),
      .concatenated_out(concatenated_out), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .word_count(word_count), .state(dbg_state)
   );

   memory_reader #(.CNT_W(4)) dut_wrap (
      .clk(clk), .rst(w_rst), .empty(w_empty), .rd_en(w_rd_en),
      .concatenated_out(w_concatenated_out), .out_data(w_out_data),
      .out_valid(w_out_valid), .out_ready(1'b1), .busy(w_busy),
      .word_count(w_word_count), .state(w_state)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;

   logic [31:0] feed_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          got_cyc_q[$];
   int          rd_cyc_q[$];

   logic [31:0] stage_word = '0;
   bit          stage_valid = 0;
   bit          rst_edge = 0;
   bit          in_flight = 0;
   int          since_rd = -1;
   int          acc_in_word = 0;
   logic [15:0] exp_wc = '0;
   bit          stall_prev = 0;
   logic [7:0]  stall_data = '0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endfunction

   // ---------------- clock/reset and memory-driver model ----------------
   always @(posedge clk) begin
      rst_edge = rst;
      #1;
      if (stage_valid) begin
         concatenated_out = stage_word;
         stage_valid      = 0;
      end else begin
         concatenated_out = $urandom;
      end
      empty   = (feed_q.size() == 0);
      w_empty = (w_pending == 0);
   end

   always @(negedge clk) if (w_rd_en) w_pending--;

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clk) begin
      cycle++;
      if (rst_edge) begin
         check("reset_rd_en", rd_en, 0);
         check("reset_out_valid", out_valid, 0);
         check("reset_out_data", out_data, 0);
         check("reset_busy", busy, 0);
         check("reset_word_count", word_count, 0);
         check("reset_state", dbg_state, ST_IDLE);
         exp_q.delete();
         in_flight   = 0;
         since_rd    = -1;
         acc_in_word = 0;
         exp_wc      = '0;
         stall_prev  = 0;
         stage_valid = 0;
      end else begin
         if (since_rd >= 0) since_rd++;
         if (rd_en) check("rd_en_while_empty", empty, 0);
         check("busy", busy, in_flight || rd_en);
         check("word_count", word_count, exp_wc);
         if (!in_flight) check("valid_without_word", out_valid, 0);
         if (since_rd == 1) check("valid_in_capture_cycle", out_valid, 0);
         if (since_rd == 2) check("first_valid_latency", out_valid, 1);
         if (stall_prev) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_data_held", out_data, stall_data);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", out_data, 32'hFFFF_FFFF);
            end else begin
               check("out_data", out_data, exp_q[0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  got_q.push_back(out_data);
                  got_cyc_q.push_back(cycle);
                  acc_in_word++;
                  if (acc_in_word == 4) begin
                     acc_in_word = 0;
                     in_flight   = 0;
                     exp_wc      = exp_wc + 16'd1;
                  end
               end
            end
         end
         if (rd_en && feed_q.size() != 0) begin
            stage_word  = feed_q.pop_front();
            stage_valid = 1;
            for (int i = 3; i >= 0; i--) exp_q.push_back(stage_word[i*8 +: 8]);
            in_flight = 1;
            since_rd  = 0;
            rd_cyc_q.push_back(cycle);
         end
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      if (got_q.size() < n) check("timeout_bytes", got_q.size(), n);
   endtask

   task automatic wait_wrap_idle(input int budget);
      int k = 0;
      while (w_busy && k < budget) begin
         tick(1);
         k++;
      end
      if (w_busy) check("timeout_wrap_idle", w_busy, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int b;
      int r;
      tick(2);
      rst   = 1'b0;
      w_rst = 1'b0;
      tick(1);
      check("after_reset_wc", word_count, 0);
      check("after_reset_rd_en", rd_en, 0);

      // single word
      b = got_q.size();
      r = rd_cyc_q.size();
      feed_q.push_back(32'h01020304);
      wait_bytes(b + 4, 40);
      tick(2);
      check("single_b0", got_q[b+0], 8'h01);
      check("single_b1", got_q[b+1], 8'h02);
      check("single_b2", got_q[b+2], 8'h03);
      check("single_b3", got_q[b+3], 8'h04);
      for (int i = 1; i < 4; i++) check("single_consecutive", got_cyc_q[b+i] - got_cyc_q[b], i);
      check("single_rd_pulses", rd_cyc_q.size() - r, 1);
      check("single_wc", word_count, 16'd1);
      check("single_idle", busy, 0);

      // backpressure on SEND cycles 2-4
      b = got_q.size();
      r = rd_cyc_q.size();
      feed_q.push_back(32'hA1B2C3D4);
      wait_bytes(b + 1, 40);
      out_ready = 1'b0;
      tick(1);
      check("bp_hold_data", out_data, 8'hB2);
      check("bp_hold_valid", out_valid, 1);
      tick(2);
      out_ready = 1'b1;
      wait_bytes(b + 4, 40);
      tick(3);
      check("bp_b0", got_q[b+0], 8'hA1);
      check("bp_b1", got_q[b+1], 8'hB2);
      check("bp_b2", got_q[b+2], 8'hC3);
      check("bp_b3", got_q[b+3], 8'hD4);
      check("bp_stall_len", got_cyc_q[b+1] - got_cyc_q[b+0], 4);
      check("bp_rd_pulses", rd_cyc_q.size() - r, 1);
      check("bp_wc", word_count, 16'd2);

      // back-to-back words
      b = got_q.size();
      r = rd_cyc_q.size();
      feed_q.push_back(32'h11223344);
      feed_q.push_back(32'h55667788);
      wait_bytes(b + 8, 60);
      tick(2);
      for (int i = 0; i < 8; i++) check("b2b_byte", got_q[b+i], 8'h11 * (i + 1));
      check("b2b_rd_pulses", rd_cyc_q.size() - r, 2);
      if (rd_cyc_q.size() - r == 2) check("b2b_second_rd", rd_cyc_q[r+1], got_cyc_q[b+3] + 1);
      check("b2b_wc", word_count, 16'd4);

      // reset mid-word
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("mid_pre_wc", word_count, 0);
      b = got_q.size();
      feed_q.push_back(32'hDEADBEEF);
      wait_bytes(b + 2, 40);
      rst       = 1'b1;
      out_ready = 1'b0;
      tick(1);
      check("mid_valid_after_rst", out_valid, 0);
      rst       = 1'b0;
      out_ready = 1'b1;
      tick(8);
      check("mid_b0", got_q[b+0], 8'hDE);
      check("mid_b1", got_q[b+1], 8'hAD);
      check("mid_no_more_bytes", got_q.size() - b, 2);
      check("mid_wc", word_count, 0);
      check("mid_idle", busy, 0);
      check("exp_q_drained", exp_q.size(), 0);

      // counter wrap on a 4-bit word_count instance
      w_pending += 15;
      tick(3);
      wait_wrap_idle(200);
      check("wrap_pre_wc", w_word_count, 4'hF);
      w_pending += 1;
      tick(3);
      wait_wrap_idle(40);
      check("wrap_wc", w_word_count, 4'h0);
      check("wrap_pending", w_pending, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
